// File: rtl/multibyte_add_ctrl_pkg.sv
// Shared definitions for the multi-byte add/subtract controller:
// FSM state encoding and the default lane count.
package multibyte_add_ctrl_pkg;

    localparam int NBYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multibyte_add_ctrl_rca8.sv
// RCA8: 8-bit ripple-carry adder lane used once by the controller,
// which reuses it sequentially for every byte lane.
module multibyte_add_ctrl_rca8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carryInput,
    output logic [7:0] sum,
    output logic       carryOutput
);

    logic [8:0] carryChain;

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        sum           = '0;
        carryChain    = '0;
        carryChain[0] = carryInput;
        for (int i = 0; i < 8; i++) begin
            sum[i]          = a[i] ^ b[i] ^ carryChain[i];
            carryChain[i+1] = (a[i] & b[i]) | (carryChain[i] & (a[i] ^ b[i]));
        end
        carryOutput = carryChain[8];
    end

endmodule

// File: rtl/multibyte_add_ctrl.sv
// Multi-byte add/subtract controller: latches two W-bit operands on start,
// then pushes one byte lane per cycle (LSB first) through a single 8-bit
// adder, pulses done for one cycle and holds the result until the next op.
//
// Handshake: start is sampled on a rising edge and is accepted only when
// busy=0 (IDLE); it is ignored while busy=1, including the DONE cycle.
// done is a one-cycle pulse during which result/carry_out/overflow are
// valid; they then stay stable until the next accepted start.
module multibyte_add_ctrl
    import multibyte_add_ctrl_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output state_t                dbgState
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t            state;
    state_t            nextState;
    logic [W-1:0]      aReg;
    logic [W-1:0]      bReg;
    logic              subReg;
    logic [IDXW-1:0]   idx;
    logic              carryReg;
    logic [W-1:0]      resultReg;
    logic              carryOutReg;
    logic              overflowReg;

    logic [7:0]        laneA;
    logic [7:0]        laneB;
    logic [7:0]        laneSum;
    logic              laneCarry;
    logic              msbCarryIn;

    // Current lane operands; subtraction feeds the inverted b lane with
    // the initial carry set to 1 (two's complement a + ~b + 1).
    always_comb begin
        laneA = aReg[idx*8 +: 8];
        laneB = bReg[idx*8 +: 8] ^ {8{subReg}};
    end

    multibyte_add_ctrl_rca8 u_rca8 (
        .a           (laneA),
        .b           (laneB),
        .carryInput  (carryReg),
        .sum         (laneSum),
        .carryOutput (laneCarry)
    );

    // Carry into bit 7 recovered from the sum bit, used for signed overflow.
    assign msbCarryIn = laneA[7] ^ laneB[7] ^ laneSum[7];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and status decode.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-lane accumulation, final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            aReg        <= '0;
            bReg        <= '0;
            subReg      <= 1'b0;
            idx         <= '0;
            carryReg    <= 1'b0;
            resultReg   <= '0;
            carryOutReg <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg     <= a;
                        bReg     <= b;
                        subReg   <= sub;
                        idx      <= '0;
                        carryReg <= sub;
                    end
                end
                ADD: begin
                    resultReg[idx*8 +: 8] <= laneSum;
                    carryReg              <= laneCarry;
                    if (idx == LAST_IDX) begin
                        carryOutReg <= laneCarry;
                        overflowReg <= msbCarryIn ^ laneCarry;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = resultReg;
    assign carry_out = carryOutReg;
    assign overflow  = overflowReg;
    assign dbgState  = state;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Bench for multibyte_add_ctrl: directed cases with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_multibyte_add_ctrl;
    import multibyte_add_ctrl_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    state_t        dbgState;

    int checks = 0;
    int errors = 0;

    // Model state: cycles of busy remaining, pending and published results.
    int             busyLeft = 0;
    logic [W+1:0]   exp_q[$];
    logic [W-1:0]   mRes = '0;
    logic           mCo  = 1'b0;
    logic           mOv  = 1'b0;

    multibyte_add_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .dbgState  (dbgState)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, returns {overflow, carry, result}.
    function automatic logic [W+1:0] refOp(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         ov;
        if (s) wide = {1'b0, x} + {1'b0, ~y} + 1;
        else   wide = {1'b0, x} + {1'b0, y};
        r = wide[W-1:0];
        if (s) ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else   ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {ov, wide[W], r};
    endfunction

    // One clock: advance the model with the inputs seen at the edge,
    // then compare every meaningful DUT output.
    task automatic tick();
        logic [W+1:0] e;
        @(posedge clk);
        if (rst) begin
            busyLeft = 0;
            exp_q.delete();
            mRes = '0;
            mCo  = 1'b0;
            mOv  = 1'b0;
        end else if (busyLeft == 0) begin
            if (start) begin
                exp_q.push_back(refOp(sub, a, b));
                busyLeft = NB + 1;
            end
        end else begin
            busyLeft--;
            if (busyLeft == 1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    mRes = e[W-1:0];
                    mCo  = e[W];
                    mOv  = e[W+1];
                end
            end
        end
        #1;
        check("busy", W'(busy), W'(busyLeft > 0));
        check("done", W'(done), W'(busyLeft == 1));
        if (busyLeft == 0 || busyLeft == 1) begin
            check("result", result, mRes);
            check("carry_out", W'(carry_out), W'(mCo));
            check("overflow", W'(overflow), W'(mOv));
        end
    endtask

    // Driver: one operation, optional start held high for holdStart extra
    // cycles, operands scrambled after the start edge; checks literals.
    task automatic runOp(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] litRes, input logic litCo, input logic litOv,
                         input int holdStart, input string name);
        int doneCnt = 0;
        start = 1'b1; sub = s; a = x; b = y;
        tick();
        for (int i = 0; i < 12; i++) begin
            start = (i < holdStart);
            sub = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            tick();
            if (done) doneCnt++;
            if (!busy) break;
        end
        start = 1'b0;
        check({name, "_idle"}, W'(busy), '0);
        check({name, "_donecnt"}, W'(doneCnt), W'(1));
        check({name, "_model_res"}, mRes, litRes);
        check({name, "_res"}, result, litRes);
        check({name, "_co"}, W'(carry_out), W'(litCo));
        check({name, "_ov"}, W'(overflow), W'(litOv));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", W'(dbgState), W'(IDLE));
        check("reset_result", result, '0);
        tick();

        runOp(1'b0, 32'h0000000A, 32'h00000018, 32'h00000022, 1'b0, 1'b0, 0, "add_small");
        tick();
        runOp(1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 0, "add_ripple");
        runOp(1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 0, "sub_ovf");
        runOp(1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 0, "add_ovf");
        runOp(1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 0, "sub_borrow");
        runOp(1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 5, "start_held");
        repeat (3) tick();
        check("held_result", result, 32'h23456789);

        // Reset mid-operation at edge k+2.
        start = 1'b1; sub = 1'b0; a = 32'h01010101; b = 32'h02020202;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", W'(busy), '0);
        check("midrst_done", W'(done), '0);
        check("midrst_result", result, '0);
        repeat (8) tick();
        runOp(1'b0, 32'h01010101, 32'h02020202, 32'h03030303, 1'b0, 1'b0, 0, "after_rst");

        // Random traffic: start glitches, random operands, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 2) == 0);
            sub   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       a = '1;
                1:       a = 32'h80000000;
                2:       a = 32'h7FFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '1;
                1:       b = 32'h00000001;
                2:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            rst = ($urandom_range(0, 60) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
